mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the pipelined MIPS core. Consumes the two register-file read operands (rs, rt) in the execute stage, runs signed/unsigned multiply and divide over a fixed multi-cycle latency, and holds the result in internal HI/LO registers for later mfhi/mflo. Exposes a busy flag so the hazard unit can stall dependent MDU instructions.

## Interface
- MULT_CYCLES, 5: cycles busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10: cycles busy stays high for div/divu (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  issue strobe for the op on mdu_op, sampled at rising edge
- mdu_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  operand rs (GRF RD1 after forwarding)
- B  in  32  operand rt (GRF RD2 after forwarding)
- busy  out  1  registered; high while a mult/div is in flight
- HI  out  32  current HI register
- LO  out  32  current LO register

## Operation
- Reset (reset=0, any time, incl. mid-operation): HI=0, LO=0, busy=0, counter=0, pending result discarded.
- Issue accepted only on a rising edge with start=1 and busy=0; start while busy=1 is ignored (no state change).
- mult/multu/div/divu accepted: operands latched, counter loaded with MULT_CYCLES or DIV_CYCLES, busy←1.
- While busy: counter decrements each edge; HI/LO keep old values and stay readable.
- At the edge where counter reaches 0: HI/LO ← computed result, busy←0 on the same edge.
- mthi/mtlo accepted: HI←A or LO←A on that edge; busy unchanged (stays 0).
- mult: signed 32×32→64; HI=upper 32, LO=lower 32. multu: same, unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. divu: unsigned.
- Divide by zero (B=0): full DIV_CYCLES busy; HI/LO left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Result computed from latched operands; A/B changes during busy have no effect.

## Timing
- Issue edge T: busy=1 from T to T+N (N=MULT_CYCLES or DIV_CYCLES), i.e. high for exactly N cycles.
- HI/LO show new value from edge T+N; an issue with start=1 in the cycle after T+N is accepted.
- mthi/mtlo: 1-cycle latency, HI/LO updated at the issue edge.
- busy is purely registered; the hazard unit stalls on (start & op∈{1..6}) | busy, kept outside this block.
- Reset deassertion: first accepted issue is at the first rising edge with reset=1.

## Structure
- Shared header/package: mdu_op encodings (MDU_NONE…MDU_MTLO), default latency constants.
- Optional sub-module mdu_arith: purely combinational, takes latched operands + op, returns 64-bit {hi,lo} with div-by-zero flag; top holds counter, busy, HI/LO, op/operand latches.
- No other state machine beyond IDLE (busy=0) / RUN (busy=1, counter>0).

## Test plan
- reset=0 mid-div (counter=4) → busy=0, HI=LO=0 immediately without clock edge; next issue accepted normally.
- mult A=0xFFFFFFFF B=2 → busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same operands → HI=0x00000001 LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7) B=2 → after 10 cycles LO=0xFFFFFFFD HI=0xFFFFFFFF; divu A=7 B=2 → LO=3 HI=1.
- divu A=5 B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → busy 10 cycles, then HI=0x11 LO=0x22.
- mult issued, then start=1 mtlo A=0x1234 during busy → ignored; final LO equals mult result; mtlo in cycle after busy falls → LO=0x1234 next edge.
- Back-to-back: div completes at edge T+10, mult issued with start=1 in following cycle → accepted, busy high another 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM states.
// Imported by mdu and mdu_arith.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on latched operands.
// Ports: op, a, b in; result {hi,lo} and div_zero out.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    always_comb begin
        sgn     = (op == MDU_MULT) || (op == MDU_DIV);
        neg_a   = sgn & a[31];
        neg_b   = sgn & b[31];
        mag_a   = neg_a ? -a : a;
        mag_b   = neg_b ? -b : b;
        // Keep the divider X-free on a zero divisor; result is dropped anyway.
        divisor = (b == 32'd0) ? 32'd1 : mag_b;
        quo     = mag_a / divisor;
        rem     = mag_a % divisor;
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};

        result   = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV, MDU_DIVU: begin
                // Magnitude divide, then restore signs: quotient truncates
                // toward zero, remainder follows the dividend. The
                // 0x80000000 / -1 case wraps to 0x80000000 rem 0.
                div_zero = (b == 32'd0);
                result   = {(neg_a ? -rem : rem),
                            ((neg_a ^ neg_b) ? -quo : quo)};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy flag.
// Ports: clk, reset (async low), start, mdu_op, A, B in; busy, HI, LO out.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                     : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    mdu_op_e     op_q, op_n;
    logic [31:0] a_q, a_n;
    logic [31:0] b_q, b_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;

    mdu_op_e     op_in;
    logic [63:0] res;
    logic        dz;

    assign op_in = mdu_op_e'(mdu_op);

    mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (res),
        .div_zero (dz)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op_in)
                        MDU_MULT, MDU_MULTU: begin
                            op_n    = op_in;
                            a_n     = A;
                            b_n     = B;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = S_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            op_n    = op_in;
                            a_n     = A;
                            b_n     = B;
                            cnt_n   = CW'(DIV_CYCLES);
                            state_n = S_RUN;
                        end
                        MDU_MTHI: hi_n = A;
                        MDU_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Issue requests are ignored here; the last count
                // retires the result and drops busy on the same edge.
                if (cnt == CW'(1)) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    if (!dz) begin
                        hi_n = res[63:32];
                        lo_n = res[31:0];
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= MDU_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    assign busy = (state == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
// Drives on negedge, samples 1 ns after posedge.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for one edge; returns 1 ns after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = OP_NONE;
    endtask

    // Called right after an issue edge. Checks busy for exactly n
    // cycles with HI/LO held, then the new HI/LO. Operands are
    // scrambled while busy; intrude also presents mtlo while busy.
    task automatic run(input string tag, input int n,
                       input logic [31:0] oh, input logic [31:0] ol,
                       input logic [31:0] nh, input logic [31:0] nl,
                       input bit intrude);
        chk({tag, "_busy_issue"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            A = 32'hDEAD_0000 + i;
            B = 32'h0000_0003 * i;
            if (intrude) begin
                start  = 1'b1;
                mdu_op = OP_MTLO;
                A      = 32'h0000_1234;
            end
            @(posedge clk);
            #1;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hi_hold"}, HI, oh);
            chk({tag, "_lo_hold"}, LO, ol);
        end
        @(negedge clk);
        start  = 1'b0;
        mdu_op = OP_NONE;
        A      = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, nh);
        chk({tag, "_lo"}, LO, nl);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        mdu_op = OP_NONE;
        A      = '0;
        B      = '0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        run("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
            32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run("div_neg", 10, 32'h0000_0001, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        issue(OP_DIVU, 32'd7, 32'd2);
        run("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
            32'd1, 32'd3, 1'b0);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run("div_ovf", 10, 32'd1, 32'd3, 32'd0, 32'h8000_0000, 1'b0);

        issue(OP_MTHI, 32'h0000_0011, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", HI, 32'h0000_0011);
        chk("mthi_lo", LO, 32'h8000_0000);

        issue(OP_MTLO, 32'h0000_0022, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_hi", HI, 32'h0000_0011);
        chk("mtlo_lo", LO, 32'h0000_0022);

        issue(OP_RSVD, 32'hFFFF_0000, 32'd5);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", HI, 32'h0000_0011);
        chk("rsvd_lo", LO, 32'h0000_0022);

        issue(OP_DIVU, 32'd5, 32'd0);
        run("div0", 10, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0);

        issue(OP_MULT, 32'd3, 32'd4);
        run("mult_intr", 5, 32'h11, 32'h22, 32'd0, 32'd12, 1'b1);

        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        chk("mtlo_after_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_after_lo", LO, 32'h0000_1234);
        chk("mtlo_after_hi", HI, 32'd0);

        issue(OP_DIV, 32'd100, 32'd7);
        run("div_b2b", 10, 32'd0, 32'h1234, 32'd2, 32'd14, 1'b0);
        issue(OP_MULT, 32'd6, 32'd7);
        run("mult_b2b", 5, 32'd2, 32'd14, 32'd0, 32'd42, 1'b0);

        issue(OP_DIVU, 32'd100, 32'd3);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(OP_DIVU, 32'd7, 32'd2);
        run("post_rst", 10, 32'd0, 32'd0, 32'd1, 32'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
